// File: rtl/vga_seg_display_n.sv
// Seven-segment hex renderer for a VGA raster with a built-in timing generator.
// A single system clock is used throughout; a divided pixel clock-enable paces
// the raster counters and a two-stage output pipeline. The displayed value is
// captured once per frame in the vertical blanking interval, so digits never tear.
module vga_seg_display_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 4,
  parameter int X0           = 200,
  parameter int Y0           = 100,
  parameter int PITCH        = 70,
  parameter int SEG_L        = 50,
  parameter int SEG_T        = 10,
  parameter logic [NUM_DIGITS-1:0] COLON_MASK = NUM_DIGITS'(4'b0010),
  parameter int BLINK_FRAMES = 30,
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    blink_en,
  input  logic [7:0]              fg_color,
  output logic [2:0]              R,
  output logic [2:0]              G,
  output logic [1:0]              B,
  output logic                    HS,
  output logic                    VS,
  output logic                    frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIG_H    = 2 * SEG_L - SEG_T;
  localparam int DIV_W    = $clog2(DIV);
  localparam int BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Geometry constants as signed 12-bit so offsets left of / above a digit
  // compare as negative rather than wrapping to large positive numbers.
  localparam logic signed [11:0] T_S   = 12'(SEG_T);
  localparam logic signed [11:0] W_S   = 12'(SEG_L);
  localparam logic signed [11:0] H_S   = 12'(DIG_H);
  localparam logic signed [11:0] T2_S  = 12'(2 * SEG_T);
  localparam logic signed [11:0] T3_S  = 12'(3 * SEG_T);
  localparam logic signed [11:0] HT3_S = 12'(DIG_H - 3 * SEG_T);
  localparam logic signed [11:0] HT2_S = 12'(DIG_H - 2 * SEG_T);

  logic [DIV_W-1:0]        div_reg;
  logic [9:0]              h_reg;
  logic [9:0]              v_reg;
  logic                    pix_ce;
  logic                    latch;
  logic [4*NUM_DIGITS-1:0] value_shadow_reg;
  logic [NUM_DIGITS-1:0]   mask_shadow_reg;
  logic [BLK_W-1:0]        blink_cnt_reg;
  logic                    phase_reg;
  logic signed [11:0]      dy;
  logic [NUM_DIGITS-1:0]   digit_hit;
  logic [NUM_DIGITS-1:0]   colon_hit;
  logic                    pixel_hit;
  logic                    visible;
  logic                    hs_level;
  logic                    vs_level;
  logic                    s1_lit_reg;
  logic                    s1_hs_reg;
  logic                    s1_vs_reg;
  logic [7:0]              rgb_reg;
  logic                    hs_reg;
  logic                    vs_reg;

  // Segment set for a hex digit, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0:    return 7'b1111110;
      4'h1:    return 7'b0110000;
      4'h2:    return 7'b1101101;
      4'h3:    return 7'b1111001;
      4'h4:    return 7'b0110011;
      4'h5:    return 7'b1011011;
      4'h6:    return 7'b1011111;
      4'h7:    return 7'b1110000;
      4'h8:    return 7'b1111111;
      4'h9:    return 7'b1111011;
      4'hA:    return 7'b1110111;
      4'hB:    return 7'b0011111;
      4'hC:    return 7'b1001110;
      4'hD:    return 7'b0111101;
      4'hE:    return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  assign pix_ce      = (div_reg == DIV_W'(DIV - 1));
  assign latch       = pix_ce && (h_reg == 10'd0) && (v_reg == 10'(V_VISIBLE));
  assign frame_start = latch;

  // Pixel divider plus horizontal/vertical raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      h_reg   <= '0;
      v_reg   <= '0;
    end else begin
      div_reg <= pix_ce ? '0 : div_reg + DIV_W'(1);
      if (pix_ce) begin
        if (h_reg == 10'(H_TOTAL - 1)) begin
          h_reg <= '0;
          v_reg <= (v_reg == 10'(V_TOTAL - 1)) ? 10'd0 : v_reg + 10'd1;
        end else begin
          h_reg <= h_reg + 10'd1;
        end
      end
    end
  end

  // Once per frame, in vertical blanking: snapshot value/mask and step the blink timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_shadow_reg <= '0;
      mask_shadow_reg  <= '0;
      blink_cnt_reg    <= '0;
      phase_reg        <= 1'b0;
    end else if (latch) begin
      value_shadow_reg <= value;
      mask_shadow_reg  <= blank_mask;
      if (!blink_en) begin
        blink_cnt_reg <= '0;
        phase_reg     <= 1'b0;
      end else if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        phase_reg     <= !phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
      end
    end
  end

  assign dy = $signed({2'b00, v_reg}) - $signed(12'(Y0));

  // One renderer per digit; digit 0 is the rightmost box.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam int XK = X0 + (NUM_DIGITS - 1 - gi) * PITCH;
    logic signed [11:0] dx;
    logic [6:0]         segs;
    logic [6:0]         area;
    logic               in_box;

    assign dx      = $signed({2'b00, h_reg}) - $signed(12'(XK));
    assign segs    = seg_decode(value_shadow_reg[4*gi +: 4]);
    assign in_box  = (dx >= 12'sd0) && (dx < W_S) && (dy >= 12'sd0) && (dy < H_S);
    assign area[6] = (dy < T_S);
    assign area[5] = (dx >= W_S - T_S) && (dy < W_S);
    assign area[4] = (dx >= W_S - T_S) && (dy >= W_S - T_S);
    assign area[3] = (dy >= H_S - T_S);
    assign area[2] = (dx < T_S) && (dy >= W_S - T_S);
    assign area[1] = (dx < T_S) && (dy < W_S);
    assign area[0] = (dy >= W_S - T_S) && (dy < W_S);
    assign digit_hit[gi] = in_box && (|(segs & area)) && !mask_shadow_reg[gi];

    // Colon squares are centred horizontally in the gap left of this digit.
    if (gi >= 1 && COLON_MASK[gi]) begin : g_colon
      localparam int CX = XK - (PITCH - SEG_L) + (PITCH - SEG_L - SEG_T) / 2;
      logic signed [11:0] cdx;
      assign cdx = $signed({2'b00, h_reg}) - $signed(12'(CX));
      assign colon_hit[gi] = (cdx >= 12'sd0) && (cdx < T_S) &&
                             (((dy >= T2_S) && (dy < T3_S)) || ((dy >= HT3_S) && (dy < HT2_S)));
    end else begin : g_no_colon
      assign colon_hit[gi] = 1'b0;
    end
  end

  // Blinking suppresses digits only; colons stay steady.
  assign pixel_hit = ((|digit_hit) && !(blink_en && phase_reg)) || (|colon_hit);
  assign visible   = (h_reg < 10'(H_VISIBLE)) && (v_reg < 10'(V_VISIBLE));
  assign hs_level  = !((h_reg >= 10'(HS_START)) && (h_reg < 10'(HS_END)));
  assign vs_level  = !((v_reg >= 10'(VS_START)) && (v_reg < 10'(VS_END)));

  // Stage 1: register the lit flag and sync levels for the current pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_lit_reg <= 1'b0;
      s1_hs_reg  <= 1'b1;
      s1_vs_reg  <= 1'b1;
    end else if (pix_ce) begin
      s1_lit_reg <= visible && pixel_hit;
      s1_hs_reg  <= hs_level;
      s1_vs_reg  <= vs_level;
    end
  end

  // Stage 2: colour select and matching sync delay feeding the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_reg <= 8'h00;
      hs_reg  <= 1'b1;
      vs_reg  <= 1'b1;
    end else if (pix_ce) begin
      rgb_reg <= s1_lit_reg ? fg_color : 8'h00;
      hs_reg  <= s1_hs_reg;
      vs_reg  <= s1_vs_reg;
    end
  end

  assign R  = rgb_reg[7:5];
  assign G  = rgb_reg[4:2];
  assign B  = rgb_reg[1:0];
  assign HS = hs_reg;
  assign VS = vs_reg;

endmodule
